// File: rtl/dmem_sram_bridge.sv
// Bridges the core's single-cycle M-stage data port onto an SRAM-like split
// (req / addr_ok / data_ok) bus, stalling the pipeline until each access completes.
module dmem_sram_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              mem_en,
  input  logic [3:0]        mem_wen,
  input  logic [1:0]        mem_size,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic [DATA_W-1:0] mem_rdata,
  input  logic              longest_stall,
  input  logic              flush,
  output logic              stall_req,
  output logic              data_req,
  output logic              data_wr,
  output logic [1:0]        data_size,
  output logic [ADDR_W-1:0] data_addr,
  output logic [3:0]        data_wstrb,
  output logic [DATA_W-1:0] data_wdata,
  input  logic              data_addr_ok,
  input  logic              data_data_ok,
  input  logic [DATA_W-1:0] data_rdata
);

  localparam int unsigned STRB_W = 4;

  typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} stateT;

  stateT state;
  logic  discard;
  logic  isLoad;

  assign isLoad  = (data_wstrb == STRB_W'(0));
  assign data_wr = |data_wstrb;

  // Freeze the pipeline from the moment an access is seen until its data returns.
  assign stall_req = !rst && ((mem_en && (state == IDLE) && !flush) ||
                              (state == ADDR) || (state == DATA));

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      data_req   <= 1'b0;
      discard    <= 1'b0;
      mem_rdata  <= '0;
      data_addr  <= '0;
      data_wdata <= '0;
      data_wstrb <= '0;
      data_size  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (mem_en && !flush) begin
            data_addr  <= mem_addr;
            data_wdata <= mem_wdata;
            data_wstrb <= mem_wen;
            data_size  <= mem_size;
            data_req   <= 1'b1;
            state      <= ADDR;
          end
        end
        ADDR: begin
          if (data_addr_ok) begin
            data_req <= 1'b0;
            if (data_data_ok) begin
              // A flushed access that also completes this cycle has nothing left to drain.
              if (flush) begin
                state <= IDLE;
              end else begin
                if (isLoad) mem_rdata <= data_rdata;
                state <= DONE;
              end
            end else begin
              discard <= flush;
              state   <= DATA;
            end
          end else if (flush) begin
            data_req <= 1'b0;
            state    <= IDLE;
          end
        end
        DATA: begin
          if (data_data_ok) begin
            discard <= 1'b0;
            if (discard || flush) begin
              state <= IDLE;
            end else begin
              if (isLoad) mem_rdata <= data_rdata;
              state <= DONE;
            end
          end else if (flush) begin
            discard <= 1'b1;
          end
        end
        DONE: begin
          if (!longest_stall || flush) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sram_bridge.sv
// Self-checking bench for dmem_sram_bridge: directed scenarios plus random accesses
// scored against transaction-level expectations (req cycles, stall cycles, load data).
module tb_dmem_sram_bridge;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_en;
  logic [3:0]    mem_wen;
  logic [1:0]    mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          longest_stall;
  logic          flush;
  logic          stall_req;
  logic          data_req;
  logic          data_wr;
  logic [1:0]    data_size;
  logic [AW-1:0] data_addr;
  logic [3:0]    data_wstrb;
  logic [DW-1:0] data_wdata;
  logic          data_addr_ok;
  logic          data_data_ok;
  logic [DW-1:0] data_rdata;
  logic          extStall;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] expRdata;

  always #5 clk = ~clk;

  assign longest_stall = stall_req | extStall;

  dmem_sram_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .mem_en(mem_en), .mem_wen(mem_wen), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .longest_stall(longest_stall), .flush(flush), .stall_req(stall_req),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_addr(data_addr),
    .data_wstrb(data_wstrb), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
    .data_data_ok(data_data_ok), .data_rdata(data_rdata)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One core access; addr_ok arrives in req cycle a+1, data_ok d cycles after that
  // (same cycle when d==0); DONE is held for 'hold' extra cycles by another stall source.
  task automatic doAccess(input logic [3:0] wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata, input int a, input int d,
                          input logic [31:0] rdata, input int hold);
    int reqCnt = 0, stallCnt = 0, dataCnt = 0, doneCnt = 0, cyc = 0;
    bit accepted = 1'b0, delivered = 1'b0, inDone, finished = 1'b0;
    if (wen == 4'b0) expRdata = rdata;
    while (!finished && cyc < 300) begin
      @(negedge clk);
      if (cyc == 0) begin
        mem_en = 1'b1; mem_wen = wen; mem_size = size;
        mem_addr = addr; mem_wdata = wdata; flush = 1'b0; extStall = 1'b0;
      end else if (cyc == 1) begin
        mem_addr = $urandom; mem_wdata = $urandom;
      end
      data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = $urandom;
      inDone = delivered;
      if (data_req) begin
        reqCnt++;
        chk("req_addr", data_addr, addr);
        chk("req_wdata", data_wdata, wdata);
        chk("req_wstrb", 32'(data_wstrb), 32'(wen));
        chk("req_size", 32'(data_size), 32'(size));
        chk("req_wr", 32'(data_wr), 32'(wen != 4'b0));
        if (reqCnt == a + 1) begin
          data_addr_ok = 1'b1; accepted = 1'b1;
          if (d == 0) begin data_data_ok = 1'b1; data_rdata = rdata; delivered = 1'b1; end
        end
      end else if (accepted && !delivered) begin
        dataCnt++;
        if (dataCnt == d) begin data_data_ok = 1'b1; data_rdata = rdata; delivered = 1'b1; end
      end else if (inDone) begin
        extStall = (doneCnt < hold);
        chk("done_rdata", mem_rdata, expRdata);
        doneCnt++;
        if (!extStall) finished = 1'b1;
      end
      #1;
      if (stall_req) stallCnt++;
      cyc++;
    end
    chk("access_timeout", 32'(finished), 32'd1);
    chk("req_cycles", 32'(reqCnt), 32'(a + 1));
    chk("stall_cycles", 32'(stallCnt), 32'(a + 2 + d));
    chk("done_cycles", 32'(doneCnt), 32'(hold + 1));
    @(negedge clk);
    mem_en = 1'b0; extStall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0;
    #1;
    chk("post_req", 32'(data_req), 32'd0);
    chk("post_stall", 32'(stall_req), 32'd0);
  endtask

  initial begin
    logic [31:0] prev;
    logic [3:0]  wen;
    logic [1:0]  size;
    rst = 1'b1; mem_en = 1'b0; mem_wen = '0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
    flush = 1'b0; extStall = 1'b0; data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = '0;
    expRdata = '0;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(data_req), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_rdata", mem_rdata, 32'd0);
    chk("rst_addr", data_addr, 32'd0);
    rst = 1'b0;

    // Minimum-latency load, then a slow halfword store, then a load held in DONE.
    doAccess(4'b0000, 2'd2, 32'h0000_1000, 32'h0, 0, 0, 32'hDEAD_BEEF, 0);
    doAccess(4'b0011, 2'd1, 32'h0000_2002, 32'h0000_ABCD, 3, 2, 32'h5555_AAAA, 0);
    doAccess(4'b0000, 2'd2, 32'h0000_1100, 32'h0, 1, 1, 32'hCAFE_0123, 3);

    // Flush with mem_en in IDLE: no stall, no request.
    @(negedge clk); mem_en = 1'b1; flush = 1'b1; #1;
    chk("idle_flush_stall", 32'(stall_req), 32'd0);
    @(negedge clk); mem_en = 1'b0; flush = 1'b0; #1;
    chk("idle_flush_req", 32'(data_req), 32'd0);

    // Flush in ADDR without addr_ok withdraws the request.
    @(negedge clk); mem_en = 1'b1; mem_wen = 4'b0; mem_size = 2'd2; mem_addr = 32'h3000;
    @(negedge clk); chk("f4_req_up", 32'(data_req), 32'd1); flush = 1'b1;
    @(negedge clk); flush = 1'b0; mem_en = 1'b0; #1;
    chk("f4_req_drop", 32'(data_req), 32'd0);
    chk("f4_stall", 32'(stall_req), 32'd0);
    @(negedge clk); #1;
    chk("f4_no_reissue", 32'(data_req), 32'd0);

    // Flush together with addr_ok: drain the data phase, keep old load data.
    prev = expRdata;
    @(negedge clk); mem_en = 1'b1; mem_wen = 4'b0; mem_size = 2'd2; mem_addr = 32'h4000;
    @(negedge clk); chk("f5_req_up", 32'(data_req), 32'd1); data_addr_ok = 1'b1; flush = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0; flush = 1'b0; mem_en = 1'b0; #1;
    chk("f5_drain_stall1", 32'(stall_req), 32'd1);
    chk("f5_drain_req", 32'(data_req), 32'd0);
    @(negedge clk); data_data_ok = 1'b1; data_rdata = 32'h1234_5678; #1;
    chk("f5_drain_stall2", 32'(stall_req), 32'd1);
    @(negedge clk); data_data_ok = 1'b0; #1;
    chk("f5_stall_off", 32'(stall_req), 32'd0);
    chk("f5_rdata_kept", mem_rdata, prev);
    chk("f5_idle_req", 32'(data_req), 32'd0);
    doAccess(4'b0000, 2'd0, 32'h0000_4001, 32'h0, 0, 1, 32'h0000_00A5, 0);

    // Random accesses.
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 3))
        0: begin wen = 4'b0000; size = 2'($urandom_range(0, 2)); end
        1: begin wen = 4'(4'b0001 << $urandom_range(0, 3)); size = 2'd0; end
        2: begin wen = 4'(4'b0011 << (2 * $urandom_range(0, 1))); size = 2'd1; end
        default: begin wen = 4'b1111; size = 2'd2; end
      endcase
      doAccess(wen, size, $urandom, $urandom, int'($urandom_range(0, 3)),
               int'($urandom_range(0, 3)), $urandom, int'($urandom_range(0, 2)));
    end

    // Reset in the data phase: everything returns to reset values, late data_ok ignored.
    @(negedge clk); mem_en = 1'b1; mem_wen = 4'hF; mem_size = 2'd2;
    mem_addr = 32'h5004; mem_wdata = 32'hCAFE_F00D;
    @(negedge clk); data_addr_ok = 1'b1;
    @(negedge clk); data_addr_ok = 1'b0; mem_en = 1'b0; rst = 1'b1; #1;
    chk("r6_stall_in_rst", 32'(stall_req), 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    chk("r6_req", 32'(data_req), 32'd0);
    chk("r6_stall", 32'(stall_req), 32'd0);
    chk("r6_rdata", mem_rdata, 32'd0);
    chk("r6_addr", data_addr, 32'd0);
    chk("r6_wdata", data_wdata, 32'd0);
    chk("r6_wstrb", 32'(data_wstrb), 32'd0);
    chk("r6_size", 32'(data_size), 32'd0);
    chk("r6_wr", 32'(data_wr), 32'd0);
    data_data_ok = 1'b1; data_rdata = 32'h9999_7777;
    @(negedge clk); data_data_ok = 1'b0; #1;
    chk("r6_late_rdata", mem_rdata, 32'd0);
    chk("r6_late_stall", 32'(stall_req), 32'd0);
    chk("r6_late_req", 32'(data_req), 32'd0);
    expRdata = 32'd0;
    doAccess(4'b0000, 2'd2, 32'h0000_6000, 32'h0, 2, 0, 32'h0BAD_F00D, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
